// File: rtl/present_pkg.sv
// present_pkg -- shared definitions for the sequential PRESENT key schedule.
//
// Contents:
//   PRESENT_ROUNDS  number of key-schedule steps (31)
//   PRESENT_NUM_RK  number of round keys produced (32)
//   ks_state_e      key-schedule controller states
//   sbox()          PRESENT 4-bit S-box
//   inv_sbox()      PRESENT 4-bit inverse S-box (only referenced when the
//                   PRESENT_KS_DEC_EN build option is defined)
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int PRESENT_NUM_RK = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRECOMP = 2'd1,
    ST_EMIT    = 2'd2
  } ks_state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_ks_step.sv
// present_ks_step -- one combinational PRESENT key-schedule step.
//
// Build option: PRESENT_KS_DEC_EN adds the inverse step; without it only the
// forward step exists and inv is ignored.
//
// Ports:
//   kr      in  KEY_W  current key register
//   c       in  5      round counter (1..31)
//   inv     in  1      1 selects the inverse step
//   kr_next out KEY_W  key register after the step
module present_ks_step
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] kr,
  input  logic [4:0]       c,
  input  logic             inv,
  output logic [KEY_W-1:0] kr_next
);

  // Counter injection point and S-box width depend on the key size.
  localparam int CPOS    = (KEY_W == 128) ? 62 : 15;
  localparam bit TWO_NIB = (KEY_W == 128);

  logic [KEY_W-1:0] fwd_rot_s;
  logic [KEY_W-1:0] fwd_s;

  // Forward step: rotate left 61, S-box top nibble(s), XOR counter.
  always_comb begin
    fwd_rot_s = {kr[KEY_W-62:0], kr[KEY_W-1:KEY_W-61]};
    fwd_s     = fwd_rot_s;
    fwd_s[KEY_W-1 -: 4] = sbox(fwd_rot_s[KEY_W-1 -: 4]);
    fwd_s[KEY_W-5 -: 4] = TWO_NIB ? sbox(fwd_rot_s[KEY_W-5 -: 4])
                                  : fwd_rot_s[KEY_W-5 -: 4];
    fwd_s[CPOS +: 5]    = fwd_rot_s[CPOS +: 5] ^ c;
  end

`ifdef PRESENT_KS_DEC_EN
  logic [KEY_W-1:0] inv_x_s;
  logic [KEY_W-1:0] inv_s;

  // Inverse step: undo the forward operations in reverse order.
  always_comb begin
    inv_x_s = kr;
    inv_x_s[CPOS +: 5]    = kr[CPOS +: 5] ^ c;
    inv_x_s[KEY_W-1 -: 4] = inv_sbox(kr[KEY_W-1 -: 4]);
    inv_x_s[KEY_W-5 -: 4] = TWO_NIB ? inv_sbox(kr[KEY_W-5 -: 4])
                                    : kr[KEY_W-5 -: 4];
    inv_s = {inv_x_s[60:0], inv_x_s[KEY_W-1:61]};
  end

  assign kr_next = inv ? inv_s : fwd_s;
`else
  logic unused_inv_s;
  assign unused_inv_s = inv;
  assign kr_next      = fwd_s;
`endif

endmodule

// File: rtl/present_key_sched_seq.sv
// present_key_sched_seq -- sequential PRESENT key schedule.
// Accepts one user key, then streams round keys K1..K32 (or K32..K1 when
// reverse order is requested) one per accepted output beat.
//
// Build option: PRESENT_KS_DEC_EN adds the dec port, the PRECOMP state and
// the inverse step, giving reverse-order output for decryption.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   key        in   KEY_W  user key, taken when key_valid && key_ready
//   key_valid  in   1      user key offered
//   key_ready  out  1      high only while idle
//   dec        in   1      (PRESENT_KS_DEC_EN only) 1 = reverse order
//   rk         out  RK_W   current round key (top 64 bits of key register)
//   rk_idx     out  6      round number of rk, 1..32
//   rk_valid   out  1      rk/rk_idx/rk_last valid
//   rk_ready   in   1      consumer accepts the beat
//   rk_last    out  1      final beat of the sequence
module present_key_sched_seq
  import present_pkg::*;
#(
  parameter int KEY_W = 80,
  parameter int RK_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             key_valid,
  output logic             key_ready,
`ifdef PRESENT_KS_DEC_EN
  input  logic             dec,
`endif
  output logic [RK_W-1:0]  rk,
  output logic [5:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_key_sched_seq: KEY_W must be 80 or 128");
  end
  if (RK_W != 64) begin : g_bad_rk_w
    $error("present_key_sched_seq: RK_W must be 64");
  end

  ks_state_e        state_r;
  ks_state_e        state_nxt_s;
  logic [KEY_W-1:0] kr_r;
  logic [KEY_W-1:0] kr_nxt_s;
  logic [KEY_W-1:0] step_out_s;
  logic [5:0]       idx_r;
  logic [5:0]       idx_nxt_s;
  logic [4:0]       step_c_s;
  logic             step_inv_s;
  logic             valid_r;
  logic             last_r;
  logic             last_nxt_s;
  logic             rev_s;

`ifdef PRESENT_KS_DEC_EN
  logic             rev_r;
  logic             rev_nxt_s;
  logic [4:0]       cnt_r;
  logic [4:0]       cnt_nxt_s;
  assign rev_s = rev_r;
`else
  assign rev_s = 1'b0;
`endif

  present_ks_step #(
    .KEY_W (KEY_W)
  ) u_step (
    .kr      (kr_r),
    .c       (step_c_s),
    .inv     (step_inv_s),
    .kr_next (step_out_s)
  );

  // Next-state, key-register and index update.
  always_comb begin
    state_nxt_s = state_r;
    kr_nxt_s    = kr_r;
    idx_nxt_s   = idx_r;
    step_c_s    = idx_r[4:0];
    step_inv_s  = 1'b0;
`ifdef PRESENT_KS_DEC_EN
    rev_nxt_s   = rev_r;
    cnt_nxt_s   = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (key_valid) begin
          kr_nxt_s = key;
`ifdef PRESENT_KS_DEC_EN
          rev_nxt_s = dec;
          if (dec) begin
            state_nxt_s = ST_PRECOMP;
            cnt_nxt_s   = 5'd1;
            idx_nxt_s   = 6'd0;
          end else begin
            state_nxt_s = ST_EMIT;
            idx_nxt_s   = 6'd1;
          end
`else
          state_nxt_s = ST_EMIT;
          idx_nxt_s   = 6'd1;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef PRESENT_KS_DEC_EN
      // Run the forward schedule to K32 so it can be unwound backwards.
      ST_PRECOMP: begin
        step_c_s = cnt_r;
        kr_nxt_s = step_out_s;
        if (cnt_r == 5'(PRESENT_ROUNDS)) begin
          state_nxt_s = ST_EMIT;
          idx_nxt_s   = 6'(PRESENT_NUM_RK);
        end else begin
          cnt_nxt_s = cnt_r + 5'd1;
        end
      end
`endif
      ST_EMIT: begin
        if (rk_ready) begin
          if (last_r) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 6'd0;
          end else if (rev_s) begin
            // At idx 32 the low five bits are 0, so subtracting 1 gives 31.
            step_c_s   = idx_r[4:0] - 5'd1;
            step_inv_s = 1'b1;
            kr_nxt_s   = step_out_s;
            idx_nxt_s  = idx_r - 6'd1;
          end else begin
            step_c_s  = idx_r[4:0];
            kr_nxt_s  = step_out_s;
            idx_nxt_s = idx_r + 6'd1;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
`ifdef PRESENT_KS_DEC_EN
    last_nxt_s = (state_nxt_s == ST_EMIT) &&
                 (rev_nxt_s ? (idx_nxt_s == 6'd1) : (idx_nxt_s == 6'(PRESENT_NUM_RK)));
`else
    last_nxt_s = (state_nxt_s == ST_EMIT) && (idx_nxt_s == 6'(PRESENT_NUM_RK));
`endif
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Key register, index and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      kr_r    <= {KEY_W{1'b0}};
      idx_r   <= 6'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      kr_r    <= kr_nxt_s;
      idx_r   <= idx_nxt_s;
      valid_r <= (state_nxt_s == ST_EMIT);
      last_r  <= last_nxt_s;
    end
  end

`ifdef PRESENT_KS_DEC_EN
  // Direction flag and precompute counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rev_r <= 1'b0;
      cnt_r <= 5'd0;
    end else begin
      rev_r <= rev_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  assign key_ready = (state_r == ST_IDLE);
  assign rk        = kr_r[KEY_W-1 -: RK_W];
  assign rk_idx    = idx_r;
  assign rk_valid  = valid_r;
  assign rk_last   = last_r;

endmodule

// File: tb/tb_present_key_sched_seq.sv
// Testbench for present_key_sched_seq: 80-bit and 128-bit instances, a
// reference key-schedule model feeding a scoreboard queue, directed steps.
module tb_present_key_sched_seq;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [79:0]  key_a;
  logic         kv_a, kr_a, rv_a, rr_a, last_a, dec_a;
  logic [63:0]  rk_a;
  logic [5:0]   idx_a;
  logic [127:0] key_b;
  logic         kv_b, kr_b, rv_b, rr_b, last_b, dec_b;
  logic [63:0]  rk_b;
  logic [5:0]   idx_b;

  int n_chk = 0;
  int n_bad = 0;
  logic [70:0] sb_a [$];
  logic [70:0] sb_b [$];
  logic [63:0] obs_a [0:63];
  logic [63:0] obs_b [0:63];

  present_key_sched_seq #(.KEY_W(80)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .key_valid(kv_a), .key_ready(kr_a),
`ifdef PRESENT_KS_DEC_EN
    .dec(dec_a),
`endif
    .rk(rk_a), .rk_idx(idx_a), .rk_valid(rv_a), .rk_ready(rr_a), .rk_last(last_a)
  );

  present_key_sched_seq #(.KEY_W(128)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .key_valid(kv_b), .key_ready(kr_b),
`ifdef PRESENT_KS_DEC_EN
    .dec(dec_b),
`endif
    .rk(rk_b), .rk_idx(idx_b), .rk_valid(rv_b), .rk_ready(rr_b), .rk_last(last_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] step80(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = SB[t[79:76]];
    t[19:15] = t[19:15] ^ c;
    return t;
  endfunction

  function automatic logic [127:0] step128(input logic [127:0] k, input logic [4:0] c);
    logic [127:0] t;
    t = {k[66:0], k[127:67]};
    t[127:124] = SB[t[127:124]];
    t[123:120] = SB[t[123:120]];
    t[66:62]   = t[66:62] ^ c;
    return t;
  endfunction

  // Push the expected beat sequence of one 80-bit key onto the scoreboard.
  task automatic push_a(input logic [79:0] k, input bit rev);
    logic [63:0] rks [1:32];
    logic [79:0] kk;
    kk = k;
    rks[1] = kk[79:16];
    for (int i = 1; i < 32; i++) begin
      kk = step80(kk, 5'(i));
      rks[i+1] = kk[79:16];
    end
    if (rev) begin
      for (int i = 32; i >= 1; i--) sb_a.push_back({(i == 1), 6'(i), rks[i]});
    end else begin
      for (int i = 1; i <= 32; i++) sb_a.push_back({(i == 32), 6'(i), rks[i]});
    end
  endtask

  // Offer a key at a negedge; return at the negedge after acceptance.
  task automatic send_a(input logic [79:0] k, input bit dec, input bit hold);
    chk("key_ready_before_send", kr_a, 1'b1);
    key_a = k;
    kv_a  = 1'b1;
    dec_a = dec;
    @(negedge clk);
    if (!hold) kv_a = 1'b0;
  endtask

  // Consume beats of dut_a, comparing each against the scoreboard.
  task automatic drain_a(input int bp_idx, input int rst_idx, input bit hold);
    logic [70:0] e;
    logic [63:0] h_rk;
    logic [5:0]  h_idx;
    bit done = 1'b0;
    bit bp_done = 1'b0;
    int cyc = 0;
    int extra = 0;
    while (!done && cyc < 200) begin
      if (hold && kv_a && kr_a) extra++;
      if (rst_idx != 0 && rv_a && idx_a == 6'(rst_idx)) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", rv_a, 1'b0);
        chk("mid_rst_idx", idx_a, 6'd0);
        chk("mid_rst_key_ready", kr_a, 1'b1);
        chk("mid_rst_last", last_a, 1'b0);
        sb_a.delete();
        done = 1'b1;
        break;
      end
      if (bp_idx != 0 && !bp_done && rv_a && idx_a == 6'(bp_idx)) begin
        rr_a  = 1'b0;
        h_rk  = rk_a;
        h_idx = idx_a;
        repeat (5) begin
          @(negedge clk);
          chk("bp_rk_hold", rk_a, h_rk);
          chk("bp_idx_hold", idx_a, h_idx);
          chk("bp_valid_hold", rv_a, 1'b1);
        end
        rr_a = 1'b1;
        bp_done = 1'b1;
      end
      if (rv_a && rr_a) begin
        if (sb_a.size() == 0) begin
          chk("sb_a_underflow", 32'(sb_a.size()), 32'd1);
          break;
        end
        e = sb_a.pop_front();
        obs_a[idx_a] = rk_a;
        chk("beat_rk_a", rk_a, e[63:0]);
        chk("beat_idx_a", idx_a, e[69:64]);
        chk("beat_last_a", last_a, e[70]);
        if (e[70]) begin
          if (hold) kv_a = 1'b0;
          done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_a_done", done, 1'b1);
    if (rst_idx == 0) begin
      chk("ready_after_last_a", kr_a, 1'b1);
      chk("valid_after_last_a", rv_a, 1'b0);
      chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
    end
    if (hold) chk("one_key_per_seq", extra, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0]  r96;
    logic [127:0] r128;
    logic [79:0]  k80;
    logic [127:0] kk;
    logic [70:0]  e;
    int           lat;
    int           cyc;

    rst = 1'b1; key_a = '0; kv_a = 1'b0; rr_a = 1'b1; dec_a = 1'b0;
    key_b = '0; kv_b = 1'b0; rr_b = 1'b1; dec_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", kr_a, 1'b1);
    chk("rst_rk_valid", rv_a, 1'b0);
    chk("rst_rk", rk_a, 64'd0);
    chk("rst_rk_idx", idx_a, 6'd0);
    chk("rst_rk_last", last_a, 1'b0);
    chk("rst_key_ready_b", kr_b, 1'b1);
    chk("rst_rk_valid_b", rv_b, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Zero 80-bit key, forward, full throughput.
    push_a(80'd0, 1'b0);
    send_a(80'd0, 1'b0, 1'b0);
    chk("k1_valid", rv_a, 1'b1);
    chk("k1_idx", idx_a, 6'd1);
    chk("k1_rk", rk_a, 64'd0);
    drain_a(0, 0, 1'b0);
    chk("k2_rk_80", obs_a[2], 64'hC000_0000_0000_0000);

    // Zero 128-bit key on the second instance.
    kk = 128'd0;
    for (int i = 1; i <= 32; i++) begin
      sb_b.push_back({(i == 32), 6'(i), kk[127:64]});
      kk = step128(kk, 5'(i));
    end
    chk("key_ready_b_before", kr_b, 1'b1);
    key_b = 128'd0; kv_b = 1'b1;
    @(negedge clk);
    kv_b = 1'b0;
    cyc = 0;
    while (sb_b.size() != 0 && cyc < 100) begin
      if (rv_b && rr_b) begin
        e = sb_b.pop_front();
        obs_b[idx_b] = rk_b;
        chk("beat_rk_b", rk_b, e[63:0]);
        chk("beat_idx_b", idx_b, e[69:64]);
        chk("beat_last_b", last_b, e[70]);
      end
      @(negedge clk);
      cyc++;
    end
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);
    chk("k1_rk_128", obs_b[1], 64'd0);
    chk("k2_rk_128", obs_b[2], 64'hCC00_0000_0000_0000);
    chk("ready_after_last_b", kr_b, 1'b1);

    // Random key with backpressure at index 7.
    r96 = {$urandom(), $urandom(), $urandom()};
    k80 = r96[79:0];
    push_a(k80, 1'b0);
    send_a(k80, 1'b0, 1'b0);
    drain_a(7, 0, 1'b0);

    // key_valid held high for the whole stream.
    r96 = {$urandom(), $urandom(), $urandom()};
    k80 = r96[79:0];
    push_a(k80, 1'b0);
    send_a(k80, 1'b0, 1'b1);
    drain_a(0, 0, 1'b1);

    // Reset in the middle of the stream at index 12.
    r96 = {$urandom(), $urandom(), $urandom()};
    k80 = r96[79:0];
    push_a(k80, 1'b0);
    send_a(k80, 1'b0, 1'b0);
    drain_a(0, 12, 1'b0);

    // Reset wins over a same-cycle handshake.
    key_a = 80'h1234_5678_9ABC_DEF0_1357;
    kv_a  = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    kv_a = 1'b0;
    chk("rst_vs_hs_valid", rv_a, 1'b0);
    chk("rst_vs_hs_ready", kr_a, 1'b1);
    @(negedge clk);
    chk("rst_vs_hs_still_idle", rv_a, 1'b0);

    // New key after reset restarts at index 1.
    r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k80 = r128[79:0];
    push_a(k80, 1'b0);
    send_a(k80, 1'b0, 1'b0);
    chk("restart_idx", idx_a, 6'd1);
    drain_a(0, 0, 1'b0);

`ifdef PRESENT_KS_DEC_EN
    // Reverse order: 32-cycle latency, sequence reversed, final beat = key top.
    r96 = {$urandom(), $urandom(), $urandom()};
    k80 = r96[79:0];
    push_a(k80, 1'b1);
    send_a(k80, 1'b1, 1'b0);
    dec_a = 1'b0;
    chk("precomp_not_ready", kr_a, 1'b0);
    lat = 1;
    while (!rv_a && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("rev_latency", lat, 32'd32);
    chk("rev_first_idx", idx_a, 6'd32);
    drain_a(0, 0, 1'b0);
    chk("rev_final_rk", obs_a[1], k80[79:16]);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/present_key_sched_seq.md
# present_key_sched_seq

Sequential, parametrised PRESENT key schedule. It accepts one user key (80- or 128-bit, chosen by parameter) over a valid/ready handshake, then streams the 32 64-bit round keys K1..K32, one per accepted output beat. It sits between key storage and the round datapath of the iterative PRESENT core, and it replaces per-round combinational key expansion.

## Interface
- `KEY_W`, default 80: user key width; only 80 or 128 are legal, and any other value triggers an elaboration error.
- `RK_W`, default 64: round-key width, fixed at 64 (the top 64 bits of the key register).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; **synchronous, active-high**.
- `key` in KEY_W: user key; sampled when `key_valid && key_ready`.
- `key_valid` in 1: a user key is offered.
- `key_ready` out 1: high only in IDLE.
- `dec` in 1: exists only with `PRESENT_KS_DEC_EN`; sampled with `key`; 1 requests reverse order.
- `rk` out 64: current round key.
- `rk_idx` out 6: round number of `rk`, in 1..32.
- `rk_valid` out 1: `rk`/`rk_idx`/`rk_last` are valid.
- `rk_ready` in 1: consumer accepts the beat.
- `rk_last` out 1: high on the final beat of the sequence.

## Operation
- Key register `kr[KEY_W-1:0]`; `rk = kr[KEY_W-1 -: 64]`.
- Forward step with counter c (5 bits, 1..31):
  - KEY_W=80: rotate left 61; S-box on `kr[79:76]`; XOR c into `kr[19:15]`.
  - KEY_W=128: rotate left 61; S-box on `kr[127:124]` and `kr[123:120]`; XOR c into `kr[66:62]`.
- Inverse step with counter c: XOR c at the same position; inverse S-box on the same nibble(s); rotate right 61.
- States:
  - IDLE → EMIT on handshake with dec=0, loading `kr=key` and `rk_idx=1`.
  - IDLE → PRECOMP on handshake with dec=1, loading `kr=key` and c=1.
  - PRECOMP applies the forward step for c=1..31, one per cycle. After c=31 it goes to EMIT with `rk_idx=32`.
  - EMIT holds `rk_valid=1`. On each `rk_valid && rk_ready`:
    - Forward: if `rk_idx<32`, apply the forward step with c=`rk_idx` and increment.
    - Reverse: if `rk_idx>1`, apply the inverse step with c=`rk_idx-1` and decrement.
    - Acceptance with `rk_last=1` → IDLE.
- `rk_last` = (forward and `rk_idx==32`) or (reverse and `rk_idx==1`).
- The counter is 5-bit and is never XORed with 0 or 32, so there is no wrap-around.
- `key_valid` is ignored outside IDLE. No key is queued.

## Timing
- Reset values: `key_ready=1`, `rk_valid=0`, `rk=0`, `rk_idx=0`, `rk_last=0`, state IDLE, `kr=0`.
- Forward: key accepted at edge N → `rk_valid=1`, `rk_idx=1` from cycle N+1.
- Reverse: first beat (`rk_idx=32`) at cycle N+32.
- Full-throughput sequence: 32 consecutive beats. `key_ready` returns high the cycle after the last acceptance.
- With `rk_ready=0`, `rk`, `rk_idx` and `rk_last` stay stable and `rk_valid` stays 1.
- `rst` high in any state, including mid-PRECOMP or mid-EMIT, gives reset values on the next edge. `rst` takes priority over a same-cycle handshake.
- Outputs are registered; `key_ready` decodes state only.

## Configuration
- `PRESENT_KS_DEC_EN` defined: the `dec` port, the PRECOMP state and the inverse-step logic are present.
- Not defined: forward order only. There is no `dec` port or PRECOMP state, and the inverse S-box is not synthesised.

## Structure
- Package `present_pkg`: 4-bit S-box and inverse S-box functions, `PRESENT_ROUNDS=31`, `PRESENT_NUM_RK=32`, and a state enum.
- Sub-module `present_ks_step`: combinational forward/inverse step, parametrised by `KEY_W`, with inputs `kr`, `c` and `inv`.

## Test plan
- KEY_W=80, zero key, `rk_ready=1`:
  - Beat 1 → `rk=0000000000000000`, `rk_idx=1`.
  - Beat 2 → `rk=C000000000000000`.
  - `rk_last` asserts only on `rk_idx=32`.
  - `key_ready` is high on the following cycle.
- KEY_W=128, zero key → beat 1 `rk=0`; beat 2 `rk=CC00000000000000`. All 32 beats must match the golden model.
- Backpressure: drop `rk_ready` for 5 cycles at `rk_idx=7` → `rk` and `rk_idx` are held unchanged, and no beat is lost or duplicated.
- Reset mid-stream: `rst=1` at `rk_idx=12` → next cycle `rk_valid=0`, `rk_idx=0`, `key_ready=1`. A new key then restarts at `rk_idx=1`.
- With `PRESENT_KS_DEC_EN`, random 80-bit key with `dec=1`:
  - First beat appears 32 cycles after acceptance, with `rk_idx=32`.
  - The beat sequence equals the forward sequence reversed.
  - The final beat has `rk_idx=1` and `rk=key[79:16]`.
- `key_valid` held high throughout the stream → exactly one key is accepted per sequence.
